// File: rtl/tpu_result_reader.sv
// tpu_result_reader: streams C-buffer accumulator words out as row-major 32-bit elements.
// Optional RESULT_SAT8_EN clamps each lane to int8 range before it leaves the block.
module tpu_result_reader #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8:0]            M,
    input  logic [8:0]            N,
    output logic                  busy,
    output logic                  done,
    output logic                  C_wr_en,
    output logic [ADDR_W-1:0]     C_index,
    output logic [32*LANES-1:0]   C_data_in,
    input  logic [32*LANES-1:0]   C_data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_last
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] EMIT    = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    logic [2:0]          r_state;
    logic [8:0]          r_m_tot;
    logic [8:0]          r_n_tot;
    logic [8:0]          r_m;
    logic [9:0]          r_col;
    logic [ADDR_W-1:0]   r_base;
    logic [LW-1:0]       r_lane;
    logic [32*LANES-1:0] r_word;
    logic                r_done;

    logic [31:0] w_lanes [LANES];
    logic [31:0] w_lane_raw;
    logic [31:0] w_lane_out;
    logic [9:0]  w_col;
    logic        w_row_end;
    logic        w_word_end;
    logic        w_final;
    logic        w_hs;

    // Lane 0 sits in the most significant 32 bits of the word.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_lanes[i] = r_word[32*(LANES-1-i) +: 32];
    end

    assign w_lane_raw = w_lanes[r_lane];
    assign w_col      = r_col + 10'(r_lane);
    assign w_row_end  = w_col == 10'(r_n_tot) - 10'd1;
    assign w_word_end = (r_lane == LW'(LANES - 1)) || w_row_end;
    assign w_final    = w_row_end && (r_m == r_m_tot - 9'd1);
    assign w_hs       = out_valid && out_ready;

`ifdef RESULT_SAT8_EN
    assign w_lane_out = ($signed(w_lane_raw) > 32'sd127)  ? 32'd127 :
                        ($signed(w_lane_raw) < -32'sd128) ? 32'hFFFF_FF80 : w_lane_raw;
`else
    assign w_lane_out = w_lane_raw;
`endif

    assign C_wr_en   = 1'b0;
    assign C_data_in = '0;
    assign C_index   = (r_state == ISSUE) ? r_base + ADDR_W'(r_m) : '0;
    assign busy      = r_state != IDLE;
    assign done      = r_done;
    assign out_valid = r_state == EMIT;
    assign out_data  = out_valid ? w_lane_out : 32'd0;
    assign out_last  = out_valid && w_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_m_tot <= '0;
            r_n_tot <= '0;
            r_m     <= '0;
            r_col   <= '0;
            r_base  <= '0;
            r_lane  <= '0;
            r_word  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= r_state == FINISH;
            case (r_state)
                IDLE: if (start) begin
                    r_m_tot <= M;
                    r_n_tot <= N;
                    r_m     <= '0;
                    r_col   <= '0;
                    r_base  <= '0;
                    r_state <= (M == 9'd0 || N == 9'd0) ? FINISH : ISSUE;
                end
                ISSUE: r_state <= CAPTURE;
                CAPTURE: begin
                    r_word  <= C_data_out;
                    r_lane  <= '0;
                    r_state <= EMIT;
                end
                EMIT: if (w_hs) begin
                    if (!w_word_end) begin
                        r_lane <= r_lane + LW'(1);
                    end else if (w_final) begin
                        r_state <= FINISH;
                    end else if (w_row_end) begin
                        r_m     <= r_m + 9'd1;
                        r_col   <= '0;
                        r_base  <= '0;
                        r_state <= ISSUE;
                    end else begin
                        r_col   <= r_col + 10'(LANES);
                        r_base  <= r_base + ADDR_W'(r_m_tot);
                        r_state <= ISSUE;
                    end
                end
                FINISH: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_result_reader.sv
// tb_tpu_result_reader: directed checks of the C-buffer result reader with a synchronous-read C model.
module tb_tpu_result_reader;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [8:0]   M;
    logic [8:0]   N;
    logic         busy;
    logic         done;
    logic         C_wr_en;
    logic [15:0]  C_index;
    logic [127:0] C_data_in;
    logic [127:0] C_data_out;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;

    logic [127:0] mem [0:15];
    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] q_data[$];
    bit          q_last[$];
    logic [15:0] q_idx[$];
    int first_cyc, done_cyc, done_cnt, busy_cnt, hold_err, last_cyc, idx_cyc;

    tpu_result_reader #(.LANES(4), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .M(M), .N(N),
        .busy(busy), .done(done), .C_wr_en(C_wr_en), .C_index(C_index),
        .C_data_in(C_data_in), .C_data_out(C_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) C_data_out <= mem[C_index[3:0]];

    function automatic logic [31:0] ev(input int w, input int k);
        return 32'hA000_0000 + 32'(w * 16 + k);
    endfunction

    task automatic run_read(input int m, input int n, input bit bp);
        logic [31:0] prev_data;
        logic        prev_last, prev_valid, prev_ready, cand, seen_last;
        logic [15:0] cand_idx;
        logic [3:0]  pat;
        pat = 4'b1001;
        q_data.delete(); q_last.delete(); q_idx.delete();
        first_cyc = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; hold_err = 0; last_cyc = -1; idx_cyc = -1;
        prev_valid = 0; prev_ready = 1; prev_data = '0; prev_last = 0; cand = 0; cand_idx = '0; seen_last = 0;
        M = 9'(m); N = 9'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            out_ready = bp ? pat[cyc % 4] : 1'b1;
            if (cand && busy && !out_valid) begin
                q_idx.push_back(cand_idx);
                if (idx_cyc < 0) idx_cyc = cyc - 1;
            end
            cand = busy && !out_valid && !seen_last && (cyc == 1 || prev_valid);
            cand_idx = C_index;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (prev_valid && !prev_ready && out_valid && (out_data !== prev_data || out_last !== prev_last))
                hold_err++;
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                if (out_last) begin seen_last = 1; last_cyc = cyc; end
            end
            busy_cnt += int'(busy);
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data; prev_last = out_last;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; M = '0; N = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, out_valid, out_last} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got=%b want=0000", {busy, done, out_valid, out_last});
        end
        n_cmp++;
        if (out_data !== 32'd0 || C_index !== 16'd0) begin
            n_fail++; $display("FAIL reset_data got data=%h idx=%h want 0/0", out_data, C_index);
        end
        n_cmp++;
        if (C_wr_en !== 1'b0 || C_data_in !== 128'd0) begin
            n_fail++; $display("FAIL tie_off got wr_en=%b din=%h want 0", C_wr_en, C_data_in);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_m4n4;
        run_read(4, 4, 1'b0);
        n_cmp++;
        if (q_idx.size() != 4 || q_idx[0] !== 16'd0 || q_idx[1] !== 16'd1 || q_idx[2] !== 16'd2 || q_idx[3] !== 16'd3) begin
            n_fail++; $display("FAIL m4n4_index got n=%0d %p want 0,1,2,3", q_idx.size(), q_idx);
        end
        n_cmp++;
        if (q_data.size() != 16) begin
            n_fail++; $display("FAIL m4n4_count got=%0d want=16", q_data.size());
        end
        for (int i = 0; i < 16 && i < q_data.size(); i++) begin
            n_cmp++;
            if (q_data[i] !== ev(i / 4, i % 4) || q_last[i] !== (i == 15)) begin
                n_fail++; $display("FAIL m4n4_elem%0d got=%h/%b want=%h/%b", i, q_data[i], q_last[i], ev(i / 4, i % 4), i == 15);
            end
        end
        n_cmp++;
        if (idx_cyc != 1 || first_cyc != 3) begin
            n_fail++; $display("FAIL latency got idx@%0d valid@%0d want idx@1 valid@3", idx_cyc, first_cyc);
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc <= last_cyc || done_cyc > last_cyc + 2) begin
            n_fail++; $display("FAIL m4n4_done got cnt=%0d at=%0d last=%0d want one pulse just after last", done_cnt, done_cyc, last_cyc);
        end
    endtask

    task automatic check_m2n6(input string tag);
        int ew[12];
        int el[12];
        ew = '{0, 0, 0, 0, 2, 2, 1, 1, 1, 1, 3, 3};
        el = '{0, 1, 2, 3, 0, 1, 0, 1, 2, 3, 0, 1};
        n_cmp++;
        if (q_idx.size() != 4 || q_idx[0] !== 16'd0 || q_idx[1] !== 16'd2 || q_idx[2] !== 16'd1 || q_idx[3] !== 16'd3) begin
            n_fail++; $display("FAIL %s_index got n=%0d %p want 0,2,1,3", tag, q_idx.size(), q_idx);
        end
        n_cmp++;
        if (q_data.size() != 12) begin
            n_fail++; $display("FAIL %s_count got=%0d want=12", tag, q_data.size());
        end
        for (int i = 0; i < 12 && i < q_data.size(); i++) begin
            n_cmp++;
            if (q_data[i] !== ev(ew[i], el[i]) || q_last[i] !== (i == 11)) begin
                n_fail++; $display("FAIL %s_elem%0d got=%h/%b want=%h/%b", tag, i, q_data[i], q_last[i], ev(ew[i], el[i]), i == 11);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL %s_done got=%0d pulses want=1", tag, done_cnt);
        end
    endtask

    task automatic test_m2n6;
        run_read(2, 6, 1'b0);
        check_m2n6("m2n6");
    endtask

    task automatic test_backpressure;
        run_read(2, 6, 1'b1);
        check_m2n6("bp");
        n_cmp++;
        if (hold_err != 0) begin
            n_fail++; $display("FAIL bp_hold got=%0d changes while stalled want=0", hold_err);
        end
    endtask

    task automatic test_n0;
        run_read(3, 0, 1'b0);
        n_cmp++;
        if (q_data.size() != 0 || q_idx.size() != 0) begin
            n_fail++; $display("FAIL n0_activity got elems=%0d reads=%0d want 0/0", q_data.size(), q_idx.size());
        end
        n_cmp++;
        if (done_cyc != 2 || done_cnt != 1) begin
            n_fail++; $display("FAIL n0_done got at=%0d cnt=%0d want at=2 cnt=1", done_cyc, done_cnt);
        end
        n_cmp++;
        if (busy_cnt != 1) begin
            n_fail++; $display("FAIL n0_busy got=%0d cycles want=1", busy_cnt);
        end
    endtask

    task automatic test_rst_mid;
        int hs;
        int dcnt;
        hs = 0; dcnt = 0;
        M = 9'd4; N = 9'd4; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 30 && hs < 2; c++) begin
            if (out_valid) hs++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!out_valid) begin
            n_fail++; $display("FAIL rst_mid_setup got out_valid=%b want 1 before rst", out_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, out_valid, out_last, done} !== 4'b0000 || out_data !== 32'd0 || C_index !== 16'd0) begin
            n_fail++; $display("FAIL rst_mid_abort got busy=%b valid=%b data=%h want all 0", busy, out_valid, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            dcnt += int'(done) + int'(busy);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (dcnt != 0) begin
            n_fail++; $display("FAIL rst_mid_quiet got=%0d done/busy cycles want=0", dcnt);
        end
        run_read(1, 1, 1'b0);
        n_cmp++;
        if (q_data.size() != 1 || q_data[0] !== ev(0, 0) || q_last[0] !== 1'b1 || done_cnt != 1) begin
            n_fail++; $display("FAIL rst_mid_fresh got n=%0d d=%h want n=1 d=%h last=1", q_data.size(), q_data[0], ev(0, 0));
        end
    endtask

    task automatic test_sat;
        logic [31:0] exp[4];
        mem[0] = {32'h0000_0200, 32'hFFFF_FF00, 32'h0000_007F, 32'hFFFF_FF85};
`ifdef RESULT_SAT8_EN
        exp = '{32'd127, 32'hFFFF_FF80, 32'd127, 32'hFFFF_FF85};
`else
        exp = '{32'h0000_0200, 32'hFFFF_FF00, 32'h0000_007F, 32'hFFFF_FF85};
`endif
        run_read(1, 4, 1'b0);
        n_cmp++;
        if (q_data.size() != 4) begin
            n_fail++; $display("FAIL sat_count got=%0d want=4", q_data.size());
        end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            n_cmp++;
            if (q_data[i] !== exp[i]) begin
                n_fail++; $display("FAIL sat_lane%0d got=%h want=%h", i, q_data[i], exp[i]);
            end
        end
    endtask

    initial begin
        for (int w = 0; w < 16; w++) mem[w] = {ev(w, 0), ev(w, 1), ev(w, 2), ev(w, 3)};
        test_reset();
        test_m4n4();
        test_m2n6();
        test_backpressure();
        test_n0();
        test_rst_mid();
        test_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
